// File: rtl/iter_mul_unit.sv
// Iterative multiply / multiply-accumulate unit (MUL, MLA, UMULL, SMULL).
// Retires UNROLL multiplier bits per cycle with a start/busy/done handshake.
// Results are registered and held until the next completed operation or reset.
//
// Ports:
//   clk        clock, rising edge
//   reset      synchronous active-low reset
//   start      request, accepted in IDLE or DONE only
//   op         00 MUL, 01 MLA, 10 UMULL, 11 SMULL
//   a, b       multiplicand / multiplier
//   acc        MLA addend
//   busy       high while the operation runs (RUN and FIX)
//   done       one-cycle completion pulse
//   result_lo  low half of the result
//   result_hi  high half (zero for MUL/MLA)
//   flags      {N,Z} of the result
module iter_mul_unit #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned UNROLL = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic [1:0]       flags
);

  localparam int unsigned N    = WIDTH / UNROLL;
  localparam int unsigned W2   = 2 * WIDTH;
  localparam int unsigned CntW = $clog2(N + 1);

  localparam logic [1:0] OpMul   = 2'b00;
  localparam logic [1:0] OpMla   = 2'b01;
  localparam logic [1:0] OpSmull = 2'b11;

  typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

  state_e            state_q;
  logic [1:0]        op_q;
  logic [W2-1:0]     mcand_q;
  logic [WIDTH-1:0]  mplier_q;
  logic [WIDTH-1:0]  acc_q;
  logic              neg_q;
  logic [W2-1:0]     prod_q;
  logic [CntW-1:0]   count_q;

  // Operand conditioning at acceptance: SMULL works on magnitudes.
  // The magnitude of the most negative value is its own bit pattern read unsigned.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;

  always_comb begin
    a_neg = (op == OpSmull) && a[WIDTH-1];
    b_neg = (op == OpSmull) && b[WIDTH-1];
    a_abs = a_neg ? (~a + WIDTH'(1)) : a;
    b_abs = b_neg ? (~b + WIDTH'(1)) : b;
  end

  // Partial product for the UNROLL multiplier bits retired this cycle.
  // mcand_q is pre-shifted so it already carries the weight of bit 0.
  logic [W2-1:0] step;

  always_comb begin
    step = '0;
    for (int j = 0; j < int'(UNROLL); j++) begin
      if (mplier_q[j]) begin
        step = step + (mcand_q << j);
      end
    end
  end

  // Final correction: sign fix, MLA addend, high-half masking, flags.
  logic [W2-1:0]    fixed;
  logic [WIDTH-1:0] lo_fix, hi_fix;
  logic [1:0]       flags_fix;

  always_comb begin
    fixed  = neg_q ? (~prod_q + W2'(1)) : prod_q;
    lo_fix = fixed[WIDTH-1:0] + ((op_q == OpMla) ? acc_q : '0);
    hi_fix = op_q[1] ? fixed[W2-1:WIDTH] : '0;
    // hi_fix is zero for MUL/MLA, so one zero test covers both cases.
    flags_fix[1] = op_q[1] ? hi_fix[WIDTH-1] : lo_fix[WIDTH-1];
    flags_fix[0] = ({hi_fix, lo_fix} == '0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      op_q      <= OpMul;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      prod_q    <= '0;
      count_q   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
      flags     <= 2'b00;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          done <= 1'b0;
          if (start) begin
            op_q     <= op;
            mcand_q  <= {{WIDTH{1'b0}}, a_abs};
            mplier_q <= b_abs;
            acc_q    <= acc;
            neg_q    <= a_neg ^ b_neg;
            prod_q   <= '0;
            count_q  <= '0;
            busy     <= 1'b1;
            state_q  <= StRun;
          end else begin
            state_q  <= StIdle;
          end
        end
        StRun: begin
          prod_q   <= prod_q + step;
          mcand_q  <= mcand_q << UNROLL;
          mplier_q <= mplier_q >> UNROLL;
          count_q  <= count_q + CntW'(1);
          if (count_q == CntW'(N - 1)) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          result_lo <= lo_fix;
          result_hi <= hi_fix;
          flags     <= flags_fix;
          busy      <= 1'b0;
          done      <= 1'b1;
          state_q   <= StDone;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_mul_unit.sv
module tb_iter_mul_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, start4;
  logic [1:0]  op;
  logic [31:0] a, b, acc;
  logic        busy, done, busy4, done4;
  logic [31:0] result_lo, result_hi, lo4, hi4;
  logic [1:0]  flags, flags4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  iter_mul_unit #(.WIDTH(32), .UNROLL(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .acc       (acc),
    .busy      (busy),
    .done      (done),
    .result_lo (result_lo),
    .result_hi (result_hi),
    .flags     (flags)
  );

  iter_mul_unit #(.WIDTH(32), .UNROLL(4)) dut4 (
    .clk       (clk),
    .reset     (reset),
    .start     (start4),
    .op        (op),
    .a         (a),
    .b         (b),
    .acc       (acc),
    .busy      (busy4),
    .done      (done4),
    .result_lo (lo4),
    .result_hi (hi4),
    .flags     (flags4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one request and count edges, starting with the sampling edge, until done.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] z, output int edges);
    op = o; a = x; b = y; acc = z; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 1;
    while (!done && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int          edges;
  int          pulses;
  logic [63:0] held;

  initial begin
    reset = 1'b0; start = 1'b0; start4 = 1'b0;
    op = 2'b00; a = '0; b = '0; acc = '0;
    idle(3);
    chk("rst_busy",  {63'd0, busy}, 64'd0);
    chk("rst_done",  {63'd0, done}, 64'd0);
    chk("rst_res",   {result_hi, result_lo}, 64'd0);
    chk("rst_flags", {62'd0, flags}, 64'd0);
    reset = 1'b1;
    idle(2);

    // MUL 7*6, latency from IDLE
    issue(2'b00, 32'd7, 32'd6, 32'd0, edges);
    chk("mul_done",  {63'd0, done}, 64'd1);
    chk("mul_lat",   64'(edges), 64'd34);
    chk("mul_res",   {result_hi, result_lo}, 64'd42);
    chk("mul_flags", {62'd0, flags}, 64'd0);
    idle(1);
    chk("done_pulse", {63'd0, done}, 64'd0);
    idle(3);
    chk("hold_idle", {result_hi, result_lo}, 64'd42);

    issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, edges);
    chk("umull_res",   {result_hi, result_lo}, 64'hFFFF_FFFE_0000_0001);
    chk("umull_flags", {62'd0, flags}, 64'd2);
    idle(2);

    issue(2'b11, 32'hFFFF_FFFE, 32'd3, 32'd0, edges);
    chk("smull_neg_res",   {result_hi, result_lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    chk("smull_neg_flags", {62'd0, flags}, 64'd2);
    idle(2);

    issue(2'b11, 32'h8000_0000, 32'h8000_0000, 32'd0, edges);
    chk("smull_min_res",   {result_hi, result_lo}, 64'h4000_0000_0000_0000);
    chk("smull_min_flags", {62'd0, flags}, 64'd0);
    idle(2);

    issue(2'b11, 32'd5, 32'hFFFF_FFF9, 32'd0, edges);
    chk("smull_mix_res", {result_hi, result_lo}, 64'hFFFF_FFFF_FFFF_FFDD);
    chk("smull_lat",     64'(edges), 64'd34);
    idle(2);

    issue(2'b00, 32'h0001_0000, 32'h0001_0000, 32'd0, edges);
    chk("mul_wrap_res",   {result_hi, result_lo}, 64'd0);
    chk("mul_wrap_flags", {62'd0, flags}, 64'd1);
    idle(2);

    issue(2'b01, 32'h0001_0000, 32'h0001_0000, 32'd5, edges);
    chk("mla_wrap_res",   {result_hi, result_lo}, 64'd5);
    chk("mla_wrap_flags", {62'd0, flags}, 64'd0);
    idle(2);

    issue(2'b01, 32'd3, 32'd4, 32'hFFFF_FFF0, edges);
    chk("mla_neg_res",   {result_hi, result_lo}, 64'h0000_0000_FFFF_FFFC);
    chk("mla_neg_flags", {62'd0, flags}, 64'd2);
    idle(2);

    issue(2'b00, 32'hFFFF_FFFF, 32'd2, 32'd7, edges);
    chk("mul_hi_zero", {result_hi, result_lo}, 64'h0000_0000_FFFF_FFFE);

    // Back-to-back: accepted in the DONE cycle.
    issue(2'b10, 32'd100, 32'd200, 32'd0, edges);
    chk("b2b_lat", 64'(edges), 64'd34);
    chk("b2b_res", {result_hi, result_lo}, 64'd20000);
    idle(2);

    // Start pulse mid-RUN with different operands is ignored.
    op = 2'b00; a = 32'd7; b = 32'd6; acc = '0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 1;
    idle(5);
    edges += 5;
    op = 2'b10; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edges++;
    while (!done && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("midrun_lat", 64'(edges), 64'd34);
    chk("midrun_res", {result_hi, result_lo}, 64'd42);
    idle(1);
    chk("midrun_no_second", {63'd0, busy}, 64'd0);
    idle(2);

    // Reset mid-RUN clears everything on the next edge.
    issue(2'b10, 32'd3, 32'd5, 32'd0, edges);
    idle(1);
    op = 2'b11; a = 32'hFFFF_FFFE; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    idle(4);
    chk("pre_rst_busy", {63'd0, busy}, 64'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_busy",  {63'd0, busy}, 64'd0);
    chk("mid_rst_done",  {63'd0, done}, 64'd0);
    chk("mid_rst_res",   {result_hi, result_lo}, 64'd0);
    chk("mid_rst_flags", {62'd0, flags}, 64'd0);
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    chk("post_rst_quiet", 64'(pulses), 64'd0);

    // UNROLL=4 instance.
    op = 2'b10; a = 32'h1234_5678; b = 32'h9ABC_DEF0; acc = '0; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    edges = 1;
    while (!done4 && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("u4_lat", 64'(edges), 64'd10);
    chk("u4_res", {hi4, lo4}, 64'h0B00_EA4E_242D_2080);
    held = {hi4, lo4};
    idle(3);
    chk("u4_hold", {hi4, lo4}, held);
    chk("u4_busy", {63'd0, busy4}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
